tick_sched: RTL and testbench
=============================

# tick_sched

Clock-enable scheduler for the 50 MHz domain. Generates one-cycle 1 kHz and 50 Hz tick strobes from programmable divisors, with start/stop control and a valid/ready configuration port. Divisor changes made while running are deferred to the next slow-tick boundary, so downstream blink, scan and debounce logic never sees a runt period. Replaces free-running divided clocks: all consumers stay on `i_clk_50M` and qualify with the strobes.

## Interface
- `DIV_W`, 20: width of the fast divisor.
- `SLOW_W`, 8: width of the slow divisor.
- `FAST_DEF`, 49999: reset value of the active fast divisor (1 kHz at 50 MHz).
- `SLOW_DEF`, 19: reset value of the active slow divisor (50 Hz, counted in fast ticks).
- `i_clk_50M` in 1: the only clock; all logic runs on its rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: level, sampled each cycle; leaves IDLE.
- `i_stop` in 1: level, sampled each cycle; returns to IDLE.
- `i_cfg_valid` in 1: configuration offer.
- `o_cfg_ready` out 1: configuration accept; a transfer occurs when valid and ready are both 1 at an edge.
- `i_cfg_fast` in DIV_W: new fast divisor.
- `i_cfg_slow` in SLOW_W: new slow divisor.
- `o_tick_1K` out 1: one-cycle fast strobe.
- `o_tick_50` out 1: one-cycle slow strobe, always coincident with an `o_tick_1K` pulse.
- `o_running` out 1: high in RUN and PEND.
- `o_cfg_pend` out 1: high in PEND.

## Operation
- Reset values:
  - State is IDLE.
  - Counters are 0.
  - Active divisors are FAST_DEF and SLOW_DEF.
  - All outputs are 0 except `o_cfg_ready`, which is 1.
- Divisor rules:
  - Fast period is fast_div+1 clocks.
  - Slow period is slow_div+1 fast ticks.
  - A fast divisor of 0 is clamped to 1 when written.
  - A slow divisor of 0 is legal: `o_tick_50` then pulses on every fast tick.
- IDLE:
  - Counters are held at 0; no strobes.
  - `o_cfg_ready`=1; an accepted config is written directly to the active divisors.
  - `i_start`=1 with `i_stop`=0 goes to RUN with counters at 0.
  - Config accepted in the same cycle as start is used by that run.
- RUN:
  - fast_cnt increments each clock.
  - When fast_cnt==fast_div: fast_cnt resets to 0, `o_tick_1K` is set for one cycle, and slow_cnt advances.
  - When slow_cnt==slow_div at a fast tick: slow_cnt resets to 0 and `o_tick_50` is set in that same cycle.
  - `o_cfg_ready`=1. An accepted config goes into shadow registers and the state moves to PEND.
  - `i_start` is ignored.
- PEND:
  - `o_cfg_ready`=0; counting continues with the old divisors.
  - On the edge that issues a slow tick: the shadow is copied to the active divisors, both counters clear, and the state returns to RUN. That tick uses the old period.
  - A config accepted in RUN on a slow-tick edge waits for the next slow tick.
- Stop:
  - `i_stop`=1 in any state moves to IDLE at the next edge; stop wins over start.
  - A pending shadow config is committed to the active divisors on stop.
  - A strobe scheduled on that same edge is suppressed.
- Reset asserted mid-operation returns immediately to the reset values; shadow contents are lost.

## Timing
- Start sampled at edge 0 gives `o_running`=1 after edge 0.
- The first `o_tick_1K` is high in the cycle after edge fast_div+1, then every fast_div+1 clocks.
- The first `o_tick_50` comes (slow_div+1)·(fast_div+1) clocks after start.
- All outputs are registered; there is no combinational path from any input to any output.
- A config transfer updates `o_cfg_pend` and `o_cfg_ready` at the next edge.
- Stop sampled at edge k gives `o_running`=0 after edge k.

## Configuration
- Macro `TICK_SCHED_SQUARE_EN`.
- Defined: adds outputs `o_clk_1K` and `o_clk_50`, both registered and reset to 0.
  - Each toggles on its respective tick, giving a 50% square wave at half the tick rate.
  - Each is held at its current level in IDLE.
- Undefined: these ports and their registers are absent; behaviour is otherwise identical.

## Test plan
- Reset check: assert reset, release, sample for 100 clocks with no start -> all outputs are 0, `o_cfg_ready`=1, no strobes.
- Basic counting: in IDLE, config fast=3/slow=1, then start at edge 0 -> `o_tick_1K` after edges 4, 8, 12, 16; `o_tick_50` after edges 8 and 16 only.
- Deferred reconfig: while running fast=3/slow=1, offer fast=5/slow=0 at edge 9 -> `o_cfg_pend`=1 and ready=0 until edge 16. Slow tick occurs at 16; after that, ticks follow at 22, 28, … with `o_tick_50` on each.
- Divisor clamp: write fast=0 in IDLE and start -> `o_tick_1K` period is 2 clocks.
- Stop/start priority: assert start and stop together in RUN -> IDLE next edge and counters at 0. Stop while PEND -> the shadow is active on the next start.
- Mid-run reset: assert reset mid-period in PEND -> asynchronous return to reset values, and after restart the divisors are FAST_DEF/SLOW_DEF (1 kHz / 50 Hz).

Source files
------------

// File: rtl/tick_sched_if.sv
// Configuration port for tick_sched: a valid/ready offer of new fast/slow divisors.
// The master drives the offer and the slave (tick_sched) returns ready.
interface tick_sched_cfg_if #(
   parameter int unsigned DIV_W  = 20,
   parameter int unsigned SLOW_W = 8
);
   logic              i_cfg_valid;
   logic              o_cfg_ready;
   logic [DIV_W-1:0]  i_cfg_fast;
   logic [SLOW_W-1:0] i_cfg_slow;

   modport master (
      output i_cfg_valid,
      output i_cfg_fast,
      output i_cfg_slow,
      input  o_cfg_ready
   );

   modport slave (
      input  i_cfg_valid,
      input  i_cfg_fast,
      input  i_cfg_slow,
      output o_cfg_ready
   );
endinterface

// File: rtl/tick_sched.sv
// 1 kHz / 50 Hz clock-enable scheduler with start/stop and deferred divisor reconfiguration.
// Optional square-wave outputs o_clk_1K / o_clk_50 are enabled by defining TICK_SCHED_SQUARE_EN.
module tick_sched #(
   parameter int unsigned DIV_W    = 20,
   parameter int unsigned SLOW_W   = 8,
   parameter int unsigned FAST_DEF = 49999,
   parameter int unsigned SLOW_DEF = 19
) (
   input  logic            i_clk_50M,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_stop,
   tick_sched_cfg_if.slave cfg,
   output logic            o_tick_1K,
   output logic            o_tick_50,
   output logic            o_running,
   output logic            o_cfg_pend
`ifdef TICK_SCHED_SQUARE_EN
   ,
   output logic            o_clk_1K,
   output logic            o_clk_50
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  fast_cnt_q, fast_cnt_d;
   logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
   logic [DIV_W-1:0]  fast_div_q, fast_div_d;
   logic [SLOW_W-1:0] slow_div_q, slow_div_d;
   logic [DIV_W-1:0]  sh_fast_q, sh_fast_d;
   logic [SLOW_W-1:0] sh_slow_q, sh_slow_d;
   logic              tick1k_q, tick1k_d;
   logic              tick50_q, tick50_d;
   logic              running_q, running_d;
   logic              pend_q, pend_d;
   logic              ready_q, ready_d;
`ifdef TICK_SCHED_SQUARE_EN
   logic              clk1k_q, clk1k_d;
   logic              clk50_q, clk50_d;
`endif

   logic              xfer;
   logic              fast_wrap;
   logic              slow_wrap;
   logic [DIV_W-1:0]  cfg_fast_cl;

   assign xfer        = cfg.i_cfg_valid && ready_q;
   assign fast_wrap   = (fast_cnt_q == fast_div_q);
   assign slow_wrap   = fast_wrap && (slow_cnt_q == slow_div_q);
   assign cfg_fast_cl = (cfg.i_cfg_fast == '0) ? DIV_W'(1) : cfg.i_cfg_fast;

   always_comb begin
      state_d    = state_q;
      fast_cnt_d = fast_cnt_q;
      slow_cnt_d = slow_cnt_q;
      fast_div_d = fast_div_q;
      slow_div_d = slow_div_q;
      sh_fast_d  = sh_fast_q;
      sh_slow_d  = sh_slow_q;
      tick1k_d   = 1'b0;
      tick50_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            fast_cnt_d = '0;
            slow_cnt_d = '0;
            if (xfer) begin
               fast_div_d = cfg_fast_cl;
               slow_div_d = cfg.i_cfg_slow;
            end
            if (i_start && !i_stop) begin
               state_d = RUN;
            end
         end

         RUN, PEND: begin
            if (i_stop) begin
               // Stop suppresses any strobe due on this edge; a waiting config
               // (shadowed, or offered on this very edge) becomes active now.
               state_d    = IDLE;
               fast_cnt_d = '0;
               slow_cnt_d = '0;
               if (state_q == PEND) begin
                  fast_div_d = sh_fast_q;
                  slow_div_d = sh_slow_q;
               end else if (xfer) begin
                  fast_div_d = cfg_fast_cl;
                  slow_div_d = cfg.i_cfg_slow;
               end
            end else begin
               if (fast_wrap) begin
                  fast_cnt_d = '0;
                  tick1k_d   = 1'b1;
                  if (slow_wrap) begin
                     slow_cnt_d = '0;
                     tick50_d   = 1'b1;
                  end else begin
                     slow_cnt_d = slow_cnt_q + SLOW_W'(1);
                  end
               end else begin
                  fast_cnt_d = fast_cnt_q + DIV_W'(1);
               end

               if (state_q == RUN) begin
                  if (xfer) begin
                     sh_fast_d = cfg_fast_cl;
                     sh_slow_d = cfg.i_cfg_slow;
                     state_d   = PEND;
                  end
               end else if (slow_wrap) begin
                  fast_div_d = sh_fast_q;
                  slow_div_d = sh_slow_q;
                  fast_cnt_d = '0;
                  slow_cnt_d = '0;
                  state_d    = RUN;
               end
            end
         end

         default: begin
            state_d    = IDLE;
            fast_cnt_d = '0;
            slow_cnt_d = '0;
         end
      endcase

      running_d = (state_d != IDLE);
      pend_d    = (state_d == PEND);
      ready_d   = (state_d != PEND);
`ifdef TICK_SCHED_SQUARE_EN
      clk1k_d   = clk1k_q ^ tick1k_d;
      clk50_d   = clk50_q ^ tick50_d;
`endif
   end

   always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         fast_cnt_q <= '0;
         slow_cnt_q <= '0;
         fast_div_q <= DIV_W'(FAST_DEF);
         slow_div_q <= SLOW_W'(SLOW_DEF);
         sh_fast_q  <= DIV_W'(FAST_DEF);
         sh_slow_q  <= SLOW_W'(SLOW_DEF);
         tick1k_q   <= 1'b0;
         tick50_q   <= 1'b0;
         running_q  <= 1'b0;
         pend_q     <= 1'b0;
         ready_q    <= 1'b1;
`ifdef TICK_SCHED_SQUARE_EN
         clk1k_q    <= 1'b0;
         clk50_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fast_cnt_q <= fast_cnt_d;
         slow_cnt_q <= slow_cnt_d;
         fast_div_q <= fast_div_d;
         slow_div_q <= slow_div_d;
         sh_fast_q  <= sh_fast_d;
         sh_slow_q  <= sh_slow_d;
         tick1k_q   <= tick1k_d;
         tick50_q   <= tick50_d;
         running_q  <= running_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
`ifdef TICK_SCHED_SQUARE_EN
         clk1k_q    <= clk1k_d;
         clk50_q    <= clk50_d;
`endif
      end
   end

   assign o_tick_1K       = tick1k_q;
   assign o_tick_50       = tick50_q;
   assign o_running       = running_q;
   assign o_cfg_pend      = pend_q;
   assign cfg.o_cfg_ready = ready_q;
`ifdef TICK_SCHED_SQUARE_EN
   assign o_clk_1K        = clk1k_q;
   assign o_clk_50        = clk50_q;
`endif

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: expected strobe cycles are queued by the stimulus
// and a negedge monitor pops and compares them whenever o_tick_1K is presented.
module tb_tick_sched;

   localparam int unsigned DIV_W  = 20;
   localparam int unsigned SLOW_W = 8;

   typedef struct {
      int cyc;
      bit t50;
   } tick_t;

   logic clk;
   logic rst_n;
   logic start;
   logic stop;
   logic tick_1k;
   logic tick_50;
   logic running;
   logic cfg_pend;

   int    cyc;
   int    n_pass;
   int    n_total;
   tick_t exp_q[$];

   tick_sched_cfg_if #(.DIV_W(DIV_W), .SLOW_W(SLOW_W)) cfg_if ();

   tick_sched #(
      .DIV_W   (DIV_W),
      .SLOW_W  (SLOW_W),
      .FAST_DEF(6),
      .SLOW_DEF(2)
   ) dut (
      .i_clk_50M (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_stop    (stop),
      .cfg       (cfg_if.slave),
      .o_tick_1K (tick_1k),
      .o_tick_50 (tick_50),
      .o_running (running),
      .o_cfg_pend(cfg_pend)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic push(input int c, input bit t);
      tick_t e;
      e.cyc = c;
      e.t50 = t;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic send_cfg(input int f, input int s);
      cfg_if.i_cfg_valid = 1'b1;
      cfg_if.i_cfg_fast  = DIV_W'(f);
      cfg_if.i_cfg_slow  = SLOW_W'(s);
      @(negedge clk);
      cfg_if.i_cfg_valid = 1'b0;
   endtask

   task automatic do_start(output int t0);
      t0 = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   always @(negedge clk) begin
      tick_t e;
      if (tick_1k === 1'b1) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL tick_unexpected: tick at cycle %0d (t50=%0d), required none", cyc, tick_50);
         end else begin
            e = exp_q.pop_front();
            if (cyc == e.cyc && tick_50 == e.t50) n_pass++;
            else $display("FAIL tick: got cycle %0d t50=%0d, required cycle %0d t50=%0d",
                          cyc, tick_50, e.cyc, e.t50);
         end
      end else if (tick_50 === 1'b1) begin
         n_total++;
         $display("FAIL tick50_alone: o_tick_50=1 at cycle %0d, required 0 without o_tick_1K", cyc);
      end
   end

   initial begin
      int t0;
      int t1;
      int t2;
      int bad;
      n_pass  = 0;
      n_total = 0;
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      cfg_if.i_cfg_valid = 1'b0;
      cfg_if.i_cfg_fast  = '0;
      cfg_if.i_cfg_slow  = '0;

      // Reset and idle behaviour
      repeat (3) @(negedge clk);
      check("rst_ready", cfg_if.o_cfg_ready, 1);
      check("rst_running", running, 0);
      check("rst_pend", cfg_pend, 0);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if ({tick_1k, tick_50, running, cfg_pend} != 4'b0000 || cfg_if.o_cfg_ready !== 1'b1) bad++;
      end
      check("reset_idle_100_bad_cycles", bad, 0);

      // Basic counting fast=3/slow=1, then deferred reconfig to fast=5/slow=0
      send_cfg(3, 1);
      check("idle_cfg_ready", cfg_if.o_cfg_ready, 1);
      check("idle_cfg_pend", cfg_pend, 0);
      do_start(t0);
      check("start_running", running, 1);
      push(t0 + 4, 0);  push(t0 + 8, 1);  push(t0 + 12, 0); push(t0 + 16, 1);
      push(t0 + 22, 1); push(t0 + 28, 1); push(t0 + 34, 1);
      wait_cyc(t0 + 8);
      send_cfg(5, 0);
      check("pend_after_offer", cfg_pend, 1);
      check("ready_after_offer", cfg_if.o_cfg_ready, 0);
      wait_cyc(t0 + 15);
      check("pend_held", cfg_pend, 1);
      check("ready_held", cfg_if.o_cfg_ready, 0);
      wait_cyc(t0 + 16);
      check("pend_cleared", cfg_pend, 0);
      check("ready_restored", cfg_if.o_cfg_ready, 1);
      check("running_after_commit", running, 1);
      wait_cyc(t0 + 35);
      pulse_stop();
      check("stop_running", running, 0);

      // Clamp: fast=0 behaves as fast=1; stop on a tick edge suppresses that tick
      send_cfg(0, 2);
      do_start(t0);
      push(t0 + 2, 0); push(t0 + 4, 0);  push(t0 + 6, 1);
      push(t0 + 8, 0); push(t0 + 10, 0); push(t0 + 12, 1);
      wait_cyc(t0 + 13);
      pulse_stop();
      check("clamp_stop_running", running, 0);

      // Start and stop together: stop wins in RUN and in IDLE
      do_start(t0);
      push(t0 + 2, 0); push(t0 + 4, 0); push(t0 + 6, 1);
      wait_cyc(t0 + 6);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      check("run_start_stop", running, 0);
      @(negedge clk);
      check("idle_start_stop", running, 0);
      start = 1'b0;
      stop  = 1'b0;

      // Stop while PEND commits the shadow
      do_start(t0);
      push(t0 + 2, 0); push(t0 + 4, 0);
      wait_cyc(t0 + 2);
      send_cfg(4, 1);
      check("pend_before_stop", cfg_pend, 1);
      wait_cyc(t0 + 4);
      pulse_stop();
      check("pend_stop_running", running, 0);
      check("pend_stop_pend", cfg_pend, 0);
      check("pend_stop_ready", cfg_if.o_cfg_ready, 1);
      do_start(t1);
      push(t1 + 5, 0); push(t1 + 10, 1);
      wait_cyc(t1 + 11);
      send_cfg(2, 0);
      check("pend_before_reset", cfg_pend, 1);

      // Asynchronous reset mid-period while PEND
      wait_cyc(t1 + 13);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_running", running, 0);
      check("async_rst_pend", cfg_pend, 0);
      check("async_rst_ready", cfg_if.o_cfg_ready, 1);
      check("async_rst_tick", tick_1k, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_start(t2);
      push(t2 + 7, 0);  push(t2 + 14, 0); push(t2 + 21, 1);
      push(t2 + 28, 0); push(t2 + 35, 0); push(t2 + 42, 1);
      wait_cyc(t2 + 43);
      pulse_stop();
      repeat (10) @(negedge clk);
      check("ticks_outstanding", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
